// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor training path: the resolved-branch
// record, the scheduler FSM encoding and the row hash used by the predictor.
package bp_pkg;

    localparam int BP_AMSB = 63;

    typedef struct packed {
        logic             pred;
        logic             tkn;
        logic [BP_AMSB:0] adr;
    } bp_rec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } bp_state_e;

    // Row index into the perceptron weight table; must match the predictor
    function automatic logic [7:0] bp_row_hash(input logic [BP_AMSB:0] adr);
        return adr[7:0] ^ adr[15:8] ^ adr[23:16] ^ adr[31:24];
    endfunction

endpackage

// File: rtl/bp_lane_compact.sv
// Packs the valid commit lanes into the low slots in lane order and reports
// how many there are.
module bp_lane_compact
    import bp_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic    [LANES-1:0]             v_i,
    input  bp_rec_t [LANES-1:0]             rec_i,
    output bp_rec_t [LANES-1:0]             rec_o,
    output logic    [$clog2(LANES+1)-1:0]   cnt_o
);

    localparam int CW = $clog2(LANES + 1);
    localparam int IW = $clog2(LANES);

    logic [CW-1:0] cnt;

    // Walk lanes low to high; each valid lane lands in the next free slot
    always_comb begin
        cnt   = '0;
        rec_o = '0;
        for (int i = 0; i < LANES; i++) begin
            if (v_i[i]) begin
                rec_o[cnt[IW-1:0]] = rec_i[i];
                cnt = cnt + 1'b1;
            end
        end
    end

    assign cnt_o = cnt;

endmodule

// File: rtl/bp_train_scheduler.sv
// Collects resolved branches from the commit lanes into a FIFO and feeds them
// one at a time to the perceptron training port, holding back a record whose
// weight row was just trained until the read-modify-write gap has elapsed.
module bp_train_scheduler
    import bp_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int DEPTH   = 16,
    parameter int RMW_GAP = 2,
    parameter int DCW     = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [LANES-1:0]                br_v,
    input  logic [LANES-1:0][BP_AMSB:0]     br_adr,
    input  logic [LANES-1:0]                br_tkn,
    input  logic [LANES-1:0]                br_pred,
    input  logic                            flush,
    output logic                            trn_v,
    input  logic                            trn_rdy,
    output logic [BP_AMSB:0]                trn_adr,
    output logic                            trn_tkn,
    output logic                            trn_pred,
    output logic [7:0]                      trn_row,
    output logic [$clog2(DEPTH):0]          q_cnt,
    output logic [DCW-1:0]                  drop_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int CW  = $clog2(LANES + 1);
    localparam int GW  = $clog2(RMW_GAP + 1);
    localparam int DW1 = DCW + 1;

    bp_rec_t [LANES-1:0] lane_rec, cmp_rec;
    logic    [CW-1:0]    n_in;

    bp_rec_t             mem_q [DEPTH];
    logic    [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic    [PW-1:0]    cnt, free, n_in_w, n_acc, n_drop;
    logic    [DCW-1:0]   drop_q, drop_d;
    logic    [DW1-1:0]   drop_sum;
    logic    [GW-1:0]    gap_q, gap_d, gap_nxt;

    bp_state_e           state_q;
    logic                trn_v_q;
    bp_rec_t             trn_rec_q;
    logic    [7:0]       trn_row_q, last_row_q;

    bp_rec_t             head_rec, nxt_rec;
    logic    [7:0]       head_row, nxt_row;
    logic                accept, load_ok, reissue;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_rec[i] = '{pred: br_pred[i], tkn: br_tkn[i], adr: br_adr[i]};
    end

    bp_lane_compact #(.LANES(LANES)) u_compact (
        .v_i   (br_v),
        .rec_i (lane_rec),
        .rec_o (cmp_rec),
        .cnt_o (n_in)
    );

    // Room is judged on this cycle's occupancy; a same-cycle pop frees nothing
    assign cnt      = tail_q - head_q;
    assign free     = PW'(DEPTH) - cnt;
    assign n_in_w   = PW'(n_in);
    assign n_acc    = (n_in_w > free) ? free : n_in_w;
    assign n_drop   = n_in_w - n_acc;
    assign drop_sum = {1'b0, drop_q} + DW1'(n_drop);

    assign head_rec = mem_q[head_q[AW-1:0]];
    assign nxt_rec  = mem_q[head_q[AW-1:0] + AW'(1)];
    assign head_row = bp_row_hash(head_rec.adr);
    assign nxt_row  = bp_row_hash(nxt_rec.adr);

    // The head is loaded one cycle before trn_v rises, so the hazard is judged
    // against the gap count as it will stand when the request appears.
    assign accept  = trn_v_q & trn_rdy;
    assign load_ok = (state_q == IDLE) && !flush && (cnt != '0) &&
                     !((head_row == last_row_q) && (gap_nxt != '0));
    assign reissue = accept && !flush && (cnt > PW'(1)) && (nxt_row != trn_row_q);

    // Pointer, gap and drop-counter next state; flush keeps only a presented request
    always_comb begin
        head_d  = head_q + PW'(accept);
        tail_d  = flush ? head_q + PW'(state_q == ISSUE) : tail_q + n_acc;
        gap_nxt = (gap_q != '0) ? gap_q - 1'b1 : '0;
        gap_d   = accept ? GW'(RMW_GAP) : gap_nxt;
        drop_d  = flush ? drop_q : (drop_sum[DCW] ? '1 : drop_sum[DCW-1:0]);
    end

    // FIFO storage: accepted lanes land in consecutive slots from the tail
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int k = 0; k < LANES; k++) begin
                if (PW'(k) < n_acc)
                    mem_q[tail_q[AW-1:0] + AW'(k)] <= cmp_rec[k];
            end
        end
    end

    // Pointers, hazard gap counter and saturating drop counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            gap_q  <= '0;
            drop_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            gap_q  <= gap_d;
            drop_q <= drop_d;
        end
    end

    // Issue FSM: present the head, hold until accepted, chain when rows differ
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            trn_v_q    <= 1'b0;
            trn_rec_q  <= '0;
            trn_row_q  <= '0;
            last_row_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_ok) begin
                        state_q   <= ISSUE;
                        trn_v_q   <= 1'b1;
                        trn_rec_q <= head_rec;
                        trn_row_q <= head_row;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        last_row_q <= trn_row_q;
                        if (reissue) begin
                            trn_rec_q <= nxt_rec;
                            trn_row_q <= nxt_row;
                        end else begin
                            state_q <= IDLE;
                            trn_v_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign trn_v    = trn_v_q;
    assign trn_adr  = trn_rec_q.adr;
    assign trn_tkn  = trn_rec_q.tkn;
    assign trn_pred = trn_rec_q.pred;
    assign trn_row  = trn_row_q;
    assign q_cnt    = cnt;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bp_train_scheduler.sv
// Bench for bp_train_scheduler: a queue model of the FIFO contents, updated
// from the lane/flush rules each cycle, scoreboards every accepted training
// request; directed phases cover latency, hazard gap, stalls, overflow,
// saturation, flush and reset.
module tb_bp_train_scheduler;

    localparam int DEPTH   = 16;
    localparam int RMW_GAP = 2;

    typedef struct {
        logic [63:0] adr;
        logic        tkn;
        logic        pred;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       br_v;
    logic [3:0][63:0] br_adr;
    logic [3:0]       br_tkn, br_pred;
    logic             flush;
    logic             trn_v, trn_rdy;
    logic [63:0]      trn_adr;
    logic             trn_tkn, trn_pred;
    logic [7:0]       trn_row;
    logic [4:0]       q_cnt;
    logic [15:0]      drop_cnt;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    rec_t mq[$];
    int   mdrop    = 0;
    bit   last_ok  = 0;
    logic [7:0] last_row;
    int   last_cyc;

    bp_train_scheduler dut (
        .clk(clk), .rst(rst), .br_v(br_v), .br_adr(br_adr), .br_tkn(br_tkn),
        .br_pred(br_pred), .flush(flush), .trn_v(trn_v), .trn_rdy(trn_rdy),
        .trn_adr(trn_adr), .trn_tkn(trn_tkn), .trn_pred(trn_pred),
        .trn_row(trn_row), .q_cnt(q_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_row(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model + scoreboard, evaluated mid-cycle on stable signals
    always @(negedge clk) begin
        int   sz, fr, acc;
        rec_t r;
        if (!rst) begin
            mq.delete();
            mdrop   = 0;
            last_ok = 0;
        end else begin
            chk("q_cnt", q_cnt, mq.size());
            chk("drop_cnt", drop_cnt, mdrop);
            sz = mq.size();
            if (trn_v && trn_rdy) begin
                if (sz == 0) begin
                    chk("issue_from_empty", 1, 0);
                end else begin
                    r = mq.pop_front();
                    chk("trn_adr", trn_adr, r.adr);
                    chk("trn_tkn", trn_tkn, r.tkn);
                    chk("trn_pred", trn_pred, r.pred);
                    chk("trn_row", trn_row, ref_row(r.adr));
                    if (last_ok && trn_row == last_row)
                        chk("rmw_gap_respected", (cyc - last_cyc) >= RMW_GAP + 1, 1);
                    last_ok  = 1;
                    last_row = trn_row;
                    last_cyc = cyc;
                end
            end
            if (flush) begin
                if (trn_v && !trn_rdy) begin
                    while (mq.size() > 1) void'(mq.pop_back());
                end else begin
                    mq.delete();
                end
            end else begin
                fr  = DEPTH - sz;
                acc = 0;
                for (int i = 0; i < 4; i++) begin
                    if (br_v[i]) begin
                        if (acc < fr) begin
                            r.adr = br_adr[i]; r.tkn = br_tkn[i]; r.pred = br_pred[i];
                            mq.push_back(r);
                            acc++;
                        end else if (mdrop < 65535) begin
                            mdrop++;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_v(output int c);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!trn_v && n < 20);
        chk("trn_v_within_budget", trn_v, 1);
        c = cyc;
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < 4; i++)
            br_adr[i] = {32'($urandom), 24'h0, 8'($urandom_range(0, 3))};
        br_tkn  = 4'($urandom);
        br_pred = 4'($urandom);
    endtask

    localparam logic [63:0] STALL_ADR = 64'hDEAD_BEEF_1234_5678;

    initial begin
        int c1, c2;
        rst = 1'b0; br_v = '0; br_adr = '0; br_tkn = '0; br_pred = '0;
        flush = 1'b0; trn_rdy = 1'b0;
        tick(); tick();
        chk("reset_trn_v", trn_v, 0);
        chk("reset_q_cnt", q_cnt, 0);
        chk("reset_drop_cnt", drop_cnt, 0);
        chk("reset_trn_adr", trn_adr, 0);
        chk("reset_trn_row", trn_row, 0);
        rst = 1'b1;
        tick();

        // 1: three lanes, latency two clocks, back-to-back issue in lane order
        br_adr[0] = 64'h11; br_adr[1] = 64'h22; br_adr[2] = 64'h33; br_adr[3] = 64'h44;
        br_tkn = 4'b0101; br_pred = 4'b0011; br_v = 4'b1011;
        tick();
        br_v = '0; trn_rdy = 1'b1;
        chk("t1_q_cnt", q_cnt, 3);
        chk("t1_trn_v_plus1", trn_v, 0);
        tick(); chk("t1_trn_v_plus2", trn_v, 1);
        tick(); chk("t1_b2b_2", trn_v, 1);
        tick(); chk("t1_b2b_3", trn_v, 1);
        tick(); chk("t1_idle_after", trn_v, 0);
        repeat (4) tick();

        // 2: same row stalls RMW_GAP idle cycles, distinct rows stream
        br_adr[0] = 64'h100; br_adr[1] = 64'h100; br_v = 4'b0011;
        tick(); br_v = '0;
        wait_v(c1); wait_v(c2);
        chk("t2_same_row_spacing", c2 - c1, RMW_GAP + 1);
        repeat (5) tick();
        br_adr[0] = 64'h100; br_adr[1] = 64'h200; br_v = 4'b0011;
        tick(); br_v = '0;
        wait_v(c1); wait_v(c2);
        chk("t2_diff_row_spacing", c2 - c1, 1);
        repeat (5) tick();

        // 4: stalled request holds steady while new records queue behind it
        trn_rdy = 1'b0;
        br_adr[0] = STALL_ADR; br_tkn = 4'b0001; br_pred = 4'b0000; br_v = 4'b0001;
        tick(); br_v = '0;
        wait_v(c1);
        for (int k = 0; k < 5; k++) begin
            br_adr[1] = 64'h999; br_v = (k == 2) ? 4'b0010 : 4'b0000;
            tick();
            chk("t4_hold_v", trn_v, 1);
            chk("t4_hold_adr", trn_adr, STALL_ADR);
            chk("t4_hold_tkn", trn_tkn, 1);
            chk("t4_hold_pred", trn_pred, 0);
            chk("t4_hold_row", trn_row, ref_row(STALL_ADR));
        end
        br_v = '0; trn_rdy = 1'b1;
        repeat (8) tick();
        chk("t4_drained", q_cnt, 0);

        // 3: overflow drops high lanes, counter accumulates and saturates
        trn_rdy = 1'b0;
        rand_lanes(); br_v = 4'b1111; tick();
        rand_lanes(); tick();
        rand_lanes(); tick();
        rand_lanes(); br_v = 4'b0011; tick();
        chk("t3_fill14", q_cnt, 14);
        rand_lanes(); br_v = 4'b1111; tick();
        br_v = '0;
        chk("t3_full", q_cnt, 16);
        chk("t3_drop2", drop_cnt, 2);
        rand_lanes(); br_v = 4'b1111; tick();
        br_v = '0;
        chk("t3_drop6", drop_cnt, 6);
        br_v = 4'b1111;
        repeat (16400) tick();
        br_v = '0;
        chk("t3_saturated", drop_cnt, 16'hFFFF);

        // 5: flush keeps only the presented request
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t5a_q_after_flush", q_cnt, 1);
        chk("t5a_pending_held", trn_v, 1);
        trn_rdy = 1'b1; tick(); trn_rdy = 1'b0;
        chk("t5a_empty", q_cnt, 0);
        repeat (3) tick();
        rand_lanes(); br_v = 4'b1111; tick();
        rand_lanes(); br_v = 4'b0001; tick();
        br_v = '0;
        wait_v(c1);
        chk("t5_q5", q_cnt, 5);
        rand_lanes(); br_v = 4'b1111; flush = 1'b1; tick();
        br_v = '0; flush = 1'b0;
        chk("t5_q_after_flush", q_cnt, 1);
        trn_rdy = 1'b1; tick();
        chk("t5_q0", q_cnt, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t5_no_more_trn_v", trn_v, 0);
        end
        chk("t5_drop_unchanged", drop_cnt, 16'hFFFF);

        // 6: asynchronous reset mid-request
        trn_rdy = 1'b0;
        rand_lanes(); br_v = 4'b0011; tick(); br_v = '0;
        wait_v(c1);
        #3 rst = 1'b0;
        #1;
        chk("t6_trn_v_async", trn_v, 0);
        chk("t6_q_cnt", q_cnt, 0);
        chk("t6_drop_cnt", drop_cnt, 0);
        tick(); tick();
        rst = 1'b1;
        rand_lanes(); br_v = 4'b0001; tick(); br_v = '0;
        chk("t6_resume_q", q_cnt, 1);
        trn_rdy = 1'b1;
        repeat (6) tick();

        // Random traffic with backpressure, overflow and occasional flush
        for (int k = 0; k < 3000; k++) begin
            rand_lanes();
            br_v    = 4'($urandom);
            trn_rdy = ($urandom_range(0, 9) < 7);
            flush   = ($urandom_range(0, 63) == 0);
            tick();
        end
        br_v = '0; flush = 1'b0; trn_rdy = 1'b1;
        repeat (60) tick();
        chk("final_drained", q_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
